// File: rtl/des_iter_core.sv
// des_iter_core: iterative DES data path. One shared Feistel round is reused
// over 16 clocks between IP and FP. Round keys come from an external key
// scheduler, which reads key_round and must present the matching round_key
// in the same cycle. Encrypt and decrypt differ only in key order.
//
// Ports:
//   clock      in   rising-edge clock
//   reset_n    in   asynchronous active-low reset
//   start      in   begin a block (sampled only while idle)
//   din        in   [0:63] input block, bit 0 = DES bit 1
//   round_key  in   [0:47] key for the round on key_round
//   key_round  out  [4:0] round being computed (1..16), 0 when idle
//   busy       out  high while rounds 1..16 are in progress
//   done       out  one-cycle pulse when dout updates
//   dout       out  [0:63] FP of the round-16 result, held until next block
//   round_data out  [0:63] state register tap (DES_ITER_CORE_TAP_EN only)
//
// Build option: define DES_ITER_CORE_TAP_EN to add the round_data port.
//
// state  | meaning
// S_IDLE | waiting for start; key_round = 0
// S_RUN  | computing round key_round (1..16); round 16 returns to S_IDLE
module des_iter_core (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic [0:63] din,
  input  logic [0:47] round_key,
  output logic [4:0]  key_round,
  output logic        busy,
  output logic        done,
  output logic [0:63] dout
`ifdef DES_ITER_CORE_TAP_EN
  ,
  output logic [0:63] round_data
`endif
);

  localparam int IP_T [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};

  localparam int FP_T [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};

  localparam int E_T [48] = '{
    32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};

  localparam int P_T [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};

  // Each S-box is 64 nibbles, rows 0..3 of 16 columns, MSB nibble first.
  localparam logic [0:255] SBOX [8] = '{
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B};

  function automatic logic [0:63] perm_ip(input logic [0:63] x);
    logic [0:63] y;
    y = '0;
    for (int i = 0; i < 64; i++) y[i] = x[IP_T[i] - 1];
    return y;
  endfunction

  function automatic logic [0:63] perm_fp(input logic [0:63] x);
    logic [0:63] y;
    y = '0;
    for (int i = 0; i < 64; i++) y[i] = x[FP_T[i] - 1];
    return y;
  endfunction

  function automatic logic [0:31] f_func(input logic [0:31] r, input logic [0:47] k);
    logic [0:47] x;
    logic [0:31] s;
    logic [0:31] y;
    logic [0:5]  six;
    int          n;
    x = '0;
    s = '0;
    y = '0;
    for (int i = 0; i < 48; i++) x[i] = r[E_T[i] - 1];
    x = x ^ k;
    for (int b = 0; b < 8; b++) begin
      six = x[6*b +: 6];
      // row = {b0,b5}, column = b1..b4
      n = {26'd0, six[0], six[5], six[1:4]};
      s[4*b +: 4] = SBOX[b][4*n +: 4];
    end
    for (int i = 0; i < 32; i++) y[i] = s[P_T[i] - 1];
    return y;
  endfunction

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} fsm_t;

  fsm_t        fsm_q, fsm_d;
  logic [4:0]  round_q, round_d;
  logic [0:63] state_q, state_d;
  logic [0:63] dout_q, dout_d;
  logic        done_q, done_d;
  logic [0:31] f_out;
  logic [0:31] l_next;

  // The single shared round: f on the right half with the current round key.
  assign f_out  = f_func(state_q[32:63], round_key);
  assign l_next = state_q[0:31] ^ f_out;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fsm_q   <= S_IDLE;
      round_q <= 5'd0;
      state_q <= '0;
      dout_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      round_q <= round_d;
      state_q <= state_d;
      dout_q  <= dout_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    fsm_d   = fsm_q;
    round_d = round_q;
    state_d = state_q;
    dout_d  = dout_q;
    done_d  = 1'b0;
    case (fsm_q)
      S_IDLE: begin
        if (start) begin
          state_d = perm_ip(din);
          round_d = 5'd1;
          fsm_d   = S_RUN;
        end
      end
      S_RUN: begin
        if (round_q == 5'd16) begin
          // Last round keeps the halves unswapped (R16 L16 ordering for FP).
          state_d = {l_next, state_q[32:63]};
          dout_d  = perm_fp({l_next, state_q[32:63]});
          done_d  = 1'b1;
          round_d = 5'd0;
          fsm_d   = S_IDLE;
        end else begin
          state_d = {state_q[32:63], l_next};
          round_d = round_q + 5'd1;
        end
      end
      default: fsm_d = S_IDLE;
    endcase
  end

  assign key_round = round_q;
  assign busy      = (fsm_q == S_RUN);
  assign done      = done_q;
  assign dout      = dout_q;

`ifdef DES_ITER_CORE_TAP_EN
  assign round_data = state_q;
`endif

endmodule

// File: tb/tb_des_iter_core.sv
// tb_des_iter_core: self-checking bench for des_iter_core. A small key
// scheduler model drives round_key from key_round (forward, reverse or zero
// schedule); expected dout values are queued when a block is started and
// popped when done pulses.
module tb_des_iter_core;

  logic        clock;
  logic        reset_n;
  logic        start;
  logic [0:63] din;
  logic [0:47] round_key;
  logic [4:0]  key_round;
  logic        busy;
  logic        done;
  logic [0:63] dout;
`ifdef DES_ITER_CORE_TAP_EN
  logic [0:63] round_data;
  logic [0:63] tap_load, tap_r1, tap_r16;
`endif

  // Schedule for key 133457799BBCDFF1, K1..K16.
  localparam logic [0:47] KS [16] = '{
    48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
    48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
    48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
    48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5};

  localparam logic [0:63] PT = 64'h0123456789ABCDEF;
  localparam logic [0:63] CT = 64'h85E813540F0AB405;

  int key_mode;  // 0 = K1..K16, 1 = K16..K1, 2 = all zero
  int pass_cnt;
  int total_cnt;
  logic [0:63] sb [$];

  function automatic logic [0:47] key_for(input int mode, input logic [4:0] kr);
    int k;
    k = int'(kr);
    if (k == 0 || k > 16) return '1;  // idle: deliberately junk
    case (mode)
      0:       return KS[k-1];
      1:       return KS[16-k];
      default: return '0;
    endcase
  endfunction

  assign round_key = key_for(key_mode, key_round);

  des_iter_core dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .start     (start),
    .din       (din),
    .round_key (round_key),
    .key_round (key_round),
    .busy      (busy),
    .done      (done),
    .dout      (dout)
`ifdef DES_ITER_CORE_TAP_EN
    ,
    .round_data(round_data)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Runs one block from idle and checks pacing, latency, single done and
  // (when chk is set) the dout value from the scoreboard. extra_edge != 0
  // raises start again so that it is sampled at that edge of the block.
  task automatic run_block(input logic [0:63] blk, input logic [0:63] exp,
                           input int mode, input int extra_edge, input bit chk,
                           input string name);
    int edge_n, busy_n, done_n, lat, exp_kr;
    bit seq_ok;
    logic [0:63] exp_v;
    @(negedge clock);
    total_cnt++;
    if (key_round !== 5'd0 || busy !== 1'b0) begin
      $display("FAIL %s idle: key_round=%0d busy=%b expected 0 0", name, key_round, busy);
    end else pass_cnt++;
    key_mode = mode;
    din      = blk;
    start    = 1'b1;
    if (chk) sb.push_back(exp);
    edge_n = 0; busy_n = 0; done_n = 0; lat = 0; seq_ok = 1'b1;
    while (edge_n < 20) begin
      @(negedge clock);
      edge_n++;
      if (edge_n == 1) begin
        start = 1'b0;
        din   = {$urandom, $urandom};
      end
      if (extra_edge != 0 && edge_n == extra_edge - 1) begin
        start = 1'b1;
        din   = {$urandom, $urandom};
      end
      if (extra_edge != 0 && edge_n == extra_edge) start = 1'b0;
      exp_kr = (edge_n <= 16) ? edge_n : 0;
      if (int'(key_round) != exp_kr) seq_ok = 1'b0;
      if (busy) busy_n++;
`ifdef DES_ITER_CORE_TAP_EN
      if (edge_n == 1)  tap_load = round_data;
      if (edge_n == 2)  tap_r1   = round_data;
      if (edge_n == 17) tap_r16  = round_data;
`endif
      if (done === 1'b1) begin
        done_n++;
        if (lat == 0) lat = edge_n;
        if (chk) begin
          total_cnt++;
          if (sb.size() == 0) begin
            $display("FAIL %s extra done: dout=%h expected no done", name, dout);
          end else begin
            exp_v = sb.pop_front();
            if (dout !== exp_v)
              $display("FAIL %s dout: got %h expected %h", name, dout, exp_v);
            else pass_cnt++;
          end
        end
      end
    end
    total_cnt++;
    if (!seq_ok) $display("FAIL %s key_round sequence: last=%0d expected 1..16 then 0", name, key_round);
    else pass_cnt++;
    total_cnt++;
    if (busy_n != 16) $display("FAIL %s busy cycles: got %0d expected 16", name, busy_n);
    else pass_cnt++;
    total_cnt++;
    if (lat != 17) $display("FAIL %s latency: got %0d expected 17", name, lat);
    else pass_cnt++;
    total_cnt++;
    if (done_n != 1) $display("FAIL %s done pulses: got %0d expected 1", name, done_n);
    else pass_cnt++;
    sb.delete();
  endtask

  task automatic test_reset;
    #12;
    total_cnt++;
    if (key_round !== 5'd0 || busy !== 1'b0 || done !== 1'b0 || dout !== 64'h0)
      $display("FAIL reset values: key_round=%0d busy=%b done=%b dout=%h expected 0 0 0 0",
               key_round, busy, done, dout);
    else pass_cnt++;
`ifdef DES_ITER_CORE_TAP_EN
    total_cnt++;
    if (round_data !== 64'h0) $display("FAIL reset round_data: got %h expected 0", round_data);
    else pass_cnt++;
`endif
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_kat_encrypt;
    run_block(PT, CT, 0, 0, 1'b1, "kat_enc");
`ifdef DES_ITER_CORE_TAP_EN
    total_cnt++;
    if (tap_load !== 64'hCC00CCFFF0AAF0AA) $display("FAIL tap load: got %h expected CC00CCFFF0AAF0AA", tap_load);
    else pass_cnt++;
    total_cnt++;
    if (tap_r1 !== 64'hF0AAF0AAEF4A6544) $display("FAIL tap round1: got %h expected F0AAF0AAEF4A6544", tap_r1);
    else pass_cnt++;
    total_cnt++;
    if (tap_r16 !== 64'h0A4CD99543423234) $display("FAIL tap round16: got %h expected 0A4CD99543423234", tap_r16);
    else pass_cnt++;
`endif
  endtask

  task automatic test_decrypt;
    run_block(CT, PT, 1, 0, 1'b1, "decrypt");
  endtask

  task automatic test_zero_perm;
    run_block(64'h0, 64'h8CA64DE9C1B123A7, 2, 0, 1'b1, "zero_key");
`ifdef DES_ITER_CORE_TAP_EN
    run_block(64'h8000000000000000, 64'h0, 2, 0, 1'b0, "ip_bit1");
    total_cnt++;
    if (tap_load !== 64'h0000000001000000) $display("FAIL ip bit1: got %h expected 0000000001000000", tap_load);
    else pass_cnt++;
`endif
  endtask

  task automatic test_ignore_start;
    run_block(PT, CT, 0, 5, 1'b1, "ignore_start");
  endtask

  task automatic test_back_to_back;
    int edge_n, first_done, second_done;
    logic [0:63] exp_v;
    @(negedge clock);
    key_mode = 0; din = PT; start = 1'b1;
    sb.push_back(CT);
    edge_n = 0; first_done = 0; second_done = 0;
    while (edge_n < 40 && second_done == 0) begin
      @(negedge clock);
      edge_n++;
      if (done === 1'b1) begin
        total_cnt++;
        if (sb.size() == 0) begin
          $display("FAIL b2b extra done: dout=%h expected no done", dout);
        end else begin
          exp_v = sb.pop_front();
          if (dout !== exp_v) $display("FAIL b2b dout: got %h expected %h", dout, exp_v);
          else pass_cnt++;
        end
        if (first_done == 0) begin
          first_done = edge_n;
          key_mode = 1; din = CT;          // start still high in the done cycle
          sb.push_back(PT);
        end else second_done = edge_n;
      end else if (first_done != 0 && edge_n == first_done + 1) begin
        start = 1'b0;
        din   = {$urandom, $urandom};
      end
    end
    start = 1'b0;
    total_cnt++;
    if (first_done != 17) $display("FAIL b2b first latency: got %0d expected 17", first_done);
    else pass_cnt++;
    total_cnt++;
    if (second_done - first_done != 17)
      $display("FAIL b2b spacing: got %0d expected 17", second_done - first_done);
    else pass_cnt++;
    sb.delete();
    repeat (2) @(negedge clock);
  endtask

  task automatic test_reset_mid_block;
    int n;
    bit saw_done;
    @(negedge clock);
    key_mode = 0; din = PT; start = 1'b1;
    n = 0;
    @(negedge clock);
    start = 1'b0;
    while (key_round !== 5'd8 && n < 30) begin
      @(negedge clock);
      n++;
    end
    total_cnt++;
    if (key_round !== 5'd8) $display("FAIL reset_mid reach round8: key_round=%0d expected 8", key_round);
    else pass_cnt++;
    #1 reset_n = 1'b0;
    #1;
    total_cnt++;
    if (key_round !== 5'd0 || busy !== 1'b0 || done !== 1'b0 || dout !== 64'h0)
      $display("FAIL reset_mid async: key_round=%0d busy=%b done=%b dout=%h expected 0 0 0 0",
               key_round, busy, done, dout);
    else pass_cnt++;
`ifdef DES_ITER_CORE_TAP_EN
    total_cnt++;
    if (round_data !== 64'h0) $display("FAIL reset_mid round_data: got %h expected 0", round_data);
    else pass_cnt++;
`endif
    saw_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      if (done !== 1'b0 || busy !== 1'b0) saw_done = 1'b1;
    end
    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (done !== 1'b0) saw_done = 1'b1;
    end
    total_cnt++;
    if (saw_done) $display("FAIL reset_mid no done: saw done/busy=1 expected none");
    else pass_cnt++;
    run_block(PT, CT, 0, 0, 1'b1, "kat_after_reset");
  endtask

  initial begin
    reset_n   = 1'b0;
    start     = 1'b0;
    din       = '0;
    key_mode  = 0;
    pass_cnt  = 0;
    total_cnt = 0;
    test_reset();
    test_kat_encrypt();
    test_decrypt();
    test_zero_perm();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid_block();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/des_iter_core.md
Name: des_iter_core

Overview:
- Iterative single-round DES data path: initial permutation (IP), one Feistel round per clock for 16 clocks, final permutation (FP).
- Round keys come from an external key scheduler, paced by the `key_round` output.
- Sits between the parity-drop/round-key generator and the cipher top level.
- Encrypts or decrypts depending only on the order in which keys are supplied.

Parameters:
- None. All widths are fixed by FIPS 46-3.

Ports:
- `clock` in 1: single clock; all state changes on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: request to begin a block; sampled only while `busy`=0.
- `din` in [0:63]: input block; bit 0 = DES bit 1 (MSB).
- `round_key` in [0:47]: key for the round shown on `key_round`; must be valid in that same cycle.
- `key_round` out [4:0]: round currently being computed, 1..16; 0 when idle.
- `busy` out 1: high while rounds 1..16 are in progress.
- `done` out 1: one-cycle pulse when `dout` updates.
- `dout` out [0:63]: FP of the final round result; held until the next completion.

Behaviour:
- Bit order everywhere: index 0 = FIPS bit 1. IP, FP(=IP⁻¹), E, P and S1–S8 are exactly the FIPS 46-3 tables.
- Reset (async assert, sync release): state reg=0, `key_round`=0, `busy`=0, `done`=0, `dout`=0.
- Idle (`key_round`=0):
  - If `start`=1 at an edge: state <= IP(`din`), `key_round` <= 1, `busy` <= 1.
  - If `start`=0: nothing changes.
- Round r in 1..15: with L=state[0:31], R=state[32:63], state <= {R, L ^ f(R, `round_key`)}; `key_round` <= r+1.
- Round 16 (no swap): result = {L ^ f(R, `round_key`), R}.
  - `dout` <= FP(result); state <= result; `done` <= 1; `busy` <= 0; `key_round` <= 0.
- f(R,K) = P(S(E(R) ^ K)).
  - E expands 32→48.
  - Si takes 6 bits b0..b5: row = {b0,b5}, column = b1..b4, output 4 bits MSB first.
  - f is purely combinational within one cycle.
- Latency: `start` edge to `done` high = 17 rising edges. A new block may start in the cycle `done` is high; throughput is 1 block per 17 clocks.
- `start` while `busy`=1 is ignored, with no effect on the current block.
- `done` is high for exactly one cycle per completed block.
- `din` is sampled only at the accepting edge; later changes do not affect the block.
- `round_key` is sampled every busy cycle; X on it while idle is harmless.
- `reset_n` low mid-block aborts immediately. All outputs return to reset values and no `done` is produced.
- The 16 rounds are computed by one shared round instance; no unrolling.

Optional Feature:
- Macro `DES_ITER_CORE_TAP_EN`.
- Defined: adds output `round_data` [0:63] = current state register. Value per cycle:
  - IP(`din`) after load;
  - L(r)R(r) after round r;
  - the unswapped R16L16 after round 16.
  - Reset value 0.
- Undefined: port absent; no extra logic; all other behaviour identical.

Test Plan:
- Known-answer encrypt: key 133457799BBCDFF1 schedule K1=1B02EFFC7072 … K16=CB3D8B0E17F5, `din`=0123456789ABCDEF, pulse `start`.
  - `done` on edge 17; `dout`=85E813540F0AB405.
  - With tap: after load `round_data`=CC00CCFFF0AAF0AA; after round 1 = F0AAF0AAEF4A6544; after round 16 = 0A4CD99543423234.
- Decrypt: same keys supplied K16..K1, `din`=85E813540F0AB405 → `dout`=0123456789ABCDEF.
- Permutation identity: all `round_key`=0, `din`=0 → `dout` = DES zero-key-schedule result 8CA64DE9C1B123A7. Separately, check with tap that state after load = IP(`din`) for `din`=8000000000000000 → bit 39 set only.
- Protocol:
  - Second `start` at edge 5 of a block is ignored; `key_round` still steps 1..16 and exactly one `done` occurs.
  - `start` held high in the `done` cycle → new block accepted, next `done` 17 edges later.
- Reset: assert `reset_n`=0 at round 8 → `busy`/`done`/`key_round`/`dout` go 0 asynchronously, no `done`. After release, the known-answer test passes again.
- Key pacing: `key_round` reads 0 idle, 1..16 consecutively while busy, and 0 after `done`; `busy` is high for exactly 16 cycles.
